seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed 8-digit 7-segment scanner directly downstream of counter2bcd.
//  Consumes its 40-bit eight_segment word: 8 BCD/glyph nibbles plus 8 decimal-point bits.
//  Drives board anode/segment pins, with inter-digit ghost blanking, frame-coherent latching and per-digit blink.
// PARAMETERS
//  CLK_HZ         100_000_000  clk frequency (Hz)
//  DIGIT_HZ       1000         digit dwell rate; DIV = CLK_HZ/DIGIT_HZ cycles per digit
//  BLANK_CYCLES   100          cycles at start of each dwell with all anodes off; must be < DIV (elaboration $error)
//  BLINK_HZ       2            blink rate; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
//  AN_ACTIVE_LOW  1            1: an pins active-low
//  SEG_ACTIVE_LOW 1            1: seg/dp pins active-low
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous, active-low reset
//  eight_segment in   40  [39:8] eight nibbles, digit i = [4i+11:4i+8], digit 7 leftmost; [7:0] dp, bit i=0 lights DP of digit i
//  blink_mask    in   8   bit i=1: digit i blinks
//  an            out  8   anode enables, an[i] = digit i
//  seg           out  7   segments, seg[0]=a .. seg[6]=g
//  dp            out  1   decimal point of the active digit
//  frame_start   out  1   1-cycle pulse when a new frame is latched
// BEHAVIOUR
//  - Reset (async): all pins inactive (an=8'hFF, seg=7'h7F, dp=1 with default polarity); frame_start=0.
//    Internal state on reset: prescaler=0, index=0, blink phase=0, frame_q = all nibbles 4'hF with dp bits 1, mask_q=0.
//  - Prescaler: counts 0..DIV-1, wraps. On wrap, index advances 0->1->..->7->0.
//  - Frame latch: in every cycle with prescaler==0 and index==0, frame_q<=eight_segment, mask_q<=blink_mask, frame_start=1.
//    This includes the first cycle after reset release. Inputs are sampled nowhere else, so input changes mid-frame never tear.
//  - Glyph decode of frame_q nibble[index]:
//    - 0-9: standard digits.
//    - 4'hA: dash (g only).
//    - 4'hB-4'hF: blank.
//  - Drive per cycle:
//    - prescaler < BLANK_CYCLES: no anode active.
//    - prescaler >= BLANK_CYCLES: only an[index] active, unless mask_q[index]=1 and blink phase=1; then no anode and dp off.
//    - dp active iff frame_q[index]==0.
//  - All pins are registered: pins reflect prescaler/index state with exactly 1 cycle latency.
//    Never more than one anode is active.
//  - Polarity: logic is internal active-high; an/seg/dp are inverted at the output register per parameter.
//  - Blink counter: free-running, independent of the scan; its phase applies to all masked digits simultaneously.
//  - Reset mid-scan: immediate blank; scan restarts at digit 0 with a fresh latch on the first cycle after release.
// STRUCTURE
//  - clock_disp_pkg holds: DIGIT_DASH=4'hA, DIGIT_BLANK=4'hF, DP_ON=1'b0, and the 7-bit glyph constants
//    SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high, a=bit0).
//    counter2bcd shares the same constants.
//  - One sub-module, bcd_to_7seg: purely combinational nibble -> 7-bit active-high glyph.
//  - Everything else (prescaler, index, blink counter, frame registers, output registers) lives in seg_scan_driver.
// TESTING (CLK_HZ=1000, DIGIT_HZ=100 -> DIV=10, BLANK_CYCLES=2, BLINK_HZ=5 -> phase toggles every 100 cycles)
//  1. Reset and release:
//     - Held in reset: an=FF, seg=7F, dp=1.
//     - frame_start pulses in the 1st cycle after release, then every 80 cycles.
//  2. Date word {16'h2024,8'h08,8'h30,8'b11101010}:
//     - Digit 7 window: an=8'h7F, seg=7'b0100100 ('2').
//     - DP is lit only on digits 4, 2 and 0.
//  3. Time word {8'h12,4'hA,8'h34,4'hA,8'h56,8'hFF}:
//     - Digits 5 and 2: seg=7'b0111111 (dash).
//     - No DP is lit.
//  4. Change eight_segment while digit 3 is displayed:
//     - Digits 3..7 still show the old value.
//     - The new value appears from the next frame_start.
//  5. Blanking: every dwell shows exactly 2 cycles with an=FF; $onehot0(~an) holds in every cycle.
//  6. blink_mask=8'h03:
//     - Digits 1 and 0 are dark during phase 1 and lit during phase 0.
//     - Digits 2-7 are unaffected.
//     - Asserting rst_n low mid-dwell blanks all pins in the same cycle.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared display constants for the clock/date display path.
// Used by counter2bcd (producer of the eight_segment word) and by
// seg_scan_driver / bcd_to_7seg (consumer). Glyphs are active-high, a = bit 0.
package clock_disp_pkg;

  localparam logic [3:0] DIGIT_DASH  = 4'hA;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic       DP_ON       = 1'b0;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg_scan_driver_bcd_to_7seg.sv
// bcd_to_7seg: combinational nibble -> 7-segment glyph (active-high, a = bit 0).
// Ports:
//   nib   in  4  BCD digit or glyph code (A = dash, B..F = blank)
//   glyph out 7  segment pattern
module bcd_to_7seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nib)
      4'h0:       glyph = SEG_0;
      4'h1:       glyph = SEG_1;
      4'h2:       glyph = SEG_2;
      4'h3:       glyph = SEG_3;
      4'h4:       glyph = SEG_4;
      4'h5:       glyph = SEG_5;
      4'h6:       glyph = SEG_6;
      4'h7:       glyph = SEG_7;
      4'h8:       glyph = SEG_8;
      4'h9:       glyph = SEG_9;
      DIGIT_DASH: glyph = SEG_DASH;
      default:    glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit 7-segment scanner.
// Latches the 40-bit eight_segment word (8 nibbles + 8 active-low DP bits) once
// per frame, scans one digit per dwell with a leading ghost-blanking window,
// and blinks selected digits from a free-running blink phase.
// Ports:
//   clk           in   1   system clock
//   rst_n         in   1   async active-low reset
//   eight_segment in   40  [39:8] nibbles (digit i = [4i+11:4i+8]), [7:0] dp (0 = lit)
//   blink_mask    in   8   bit i = 1: digit i blinks
//   an            out  8   anode enables (an[i] = digit i)
//   seg           out  7   segments a..g
//   dp            out  1   decimal point of active digit
//   frame_start   out  1   pulse when a new frame is latched
module seg_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int BLANK_CYCLES   = 100,
  parameter int BLINK_HZ       = 2,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] eight_segment,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int DIV       = CLK_HZ / DIGIT_HZ;
  localparam int PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0] AN_IDLE  = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_IDLE  = SEG_ACTIVE_LOW;

  generate
    if (BLANK_CYCLES >= DIV) begin : g_bad_blank
      $error("seg_scan_driver: BLANK_CYCLES must be smaller than CLK_HZ/DIGIT_HZ");
    end
  endgenerate

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    index_q, index_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [39:0]   frame_q, frame_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_start_q, frame_start_d;

  logic          latch;
  logic [39:0]   frame_cur;
  logic [7:0]    mask_cur;
  logic [31:0]   digits;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          dark;
  logic [7:0]    an_act;
  logic          dp_act;

  bcd_to_7seg u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

  always_comb begin
    latch         = (prescaler_q == '0) && (index_q == 3'd0);
    // The latch cycle already displays the incoming word so the frame that
    // starts here is drawn entirely from one coherent sample.
    frame_cur     = latch ? eight_segment : frame_q;
    mask_cur      = latch ? blink_mask : mask_q;
    digits        = frame_cur[39:8];
    nib           = digits[{index_q, 2'b00} +: 4];
    dark          = mask_cur[index_q] & blink_ph_q;

    prescaler_d   = prescaler_q + 1'b1;
    index_d       = index_q;
    if (prescaler_q == PW'(DIV - 1)) begin
      prescaler_d = '0;
      index_d     = index_q + 3'd1;
    end

    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_ph_d    = blink_ph_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end

    frame_d       = frame_cur;
    mask_d        = mask_cur;
    frame_start_d = latch;

    an_act        = 8'h00;
    if ((prescaler_q >= PW'(BLANK_CYCLES)) && !dark) an_act = 8'b1 << index_q;
    dp_act        = (frame_cur[index_q] == DP_ON) && !dark;

    an_d          = AN_ACTIVE_LOW  ? ~an_act : an_act;
    seg_d         = SEG_ACTIVE_LOW ? ~glyph  : glyph;
    dp_d          = SEG_ACTIVE_LOW ? ~dp_act : dp_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      index_q       <= 3'd0;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      frame_q       <= 40'hFF_FFFF_FFFF;
      mask_q        <= 8'h00;
      an_q          <= AN_IDLE;
      seg_q         <= SEG_IDLE;
      dp_q          <= DP_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      index_q       <= index_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      frame_q       <= frame_d;
      mask_q        <= mask_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with a small-clock configuration:
// 10 cycles per digit, 2 blank cycles, blink phase toggles every 100 cycles.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [39:0] eight_segment;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: t counts cycles since reset release.
  int          t;
  int          last_fs;
  bit          blank_chk;
  int          blank_cnt;
  logic [39:0] m_word;
  logic [7:0]  m_mask;

  localparam logic [39:0] DATE_WORD = {16'h2024, 8'h08, 8'h30, 8'b11101010};
  localparam logic [39:0] TIME_WORD = {8'h12, 4'hA, 8'h34, 4'hA, 8'h56, 8'hFF};

  seg_scan_driver #(
    .CLK_HZ        (1000),
    .DIGIT_HZ      (100),
    .BLANK_CYCLES  (2),
    .BLINK_HZ      (5),
    .AN_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eight_segment(eight_segment),
    .blink_mask   (blink_mask),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Standard 7-segment shapes, a = bit 0, active-high.
  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      4'hA: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_an"},  64'(an), 64'(8'hFF));
    chk({tag, "_seg"}, 64'(seg), 64'(7'h7F));
    chk({tag, "_dp"},  64'(dp), 64'(1'b1));
    chk({tag, "_fs"},  64'(frame_start), 64'(1'b0));
  endtask

  // One clock of the scan: predict from t, then compare pins #1 after the edge.
  task automatic step();
    int p, idx, ph;
    bit dark, dp_on;
    logic [7:0] en, exp_an;
    logic [3:0] nib;
    logic [6:0] exp_seg;
    @(posedge clk);
    if (t % 80 == 0) begin
      m_word = eight_segment;
      m_mask = blink_mask;
    end
    p     = t % 10;
    idx   = (t / 10) % 8;
    ph    = (t / 100) % 2;
    dark  = m_mask[idx] && (ph == 1);
    en    = (p >= 2 && !dark) ? (8'h01 << idx) : 8'h00;
    nib   = m_word[8 + 4*idx +: 4];
    dp_on = (m_word[idx] == 1'b0) && !dark;
    exp_an  = ~en;
    exp_seg = ~ref_glyph(nib);
    #1;
    chk("an", 64'(an), 64'(exp_an));
    chk("an_onehot0", 64'($onehot0(~an)), 64'(1));
    chk("dp", 64'(dp), 64'(!dp_on));
    chk("frame_start", 64'(frame_start), 64'(t % 80 == 0));
    if (en != 8'h00) chk("seg", 64'(seg), 64'(exp_seg));
    if (frame_start) begin
      if (last_fs >= 0) chk("fs_period", 64'(t - last_fs), 64'(80));
      last_fs = t;
    end
    if (blank_chk) begin
      if (p == 0) blank_cnt = 0;
      if (an == 8'hFF) blank_cnt++;
      if (p == 9) chk("blank_cnt", 64'(blank_cnt), 64'(2));
    end
    t++;
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    t       = 0;
    last_fs = -1;
  endtask

  initial begin
    rst_n         = 1'b0;
    eight_segment = {$urandom, 8'($urandom)};
    blink_mask    = 8'h00;
    t             = 0;
    last_fs       = -1;
    blank_chk     = 1'b0;
    blank_cnt     = 0;
    m_word        = '0;
    m_mask        = '0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk_idle("rst");
    end

    eight_segment = DATE_WORD;
    release_reset();
    blank_chk = 1'b1;
    repeat (240) step();
    blank_chk = 1'b0;

    eight_segment = TIME_WORD;
    repeat (160) step();

    // Mid-frame change while digit 3 is on the pins.
    repeat (160) begin
      if (t % 80 == 35) eight_segment = {$urandom, 8'($urandom)};
      step();
    end

    repeat (800) begin
      if ($urandom_range(0, 19) == 0) eight_segment = {$urandom, 8'($urandom)};
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       blink_mask = 8'h00;
          1:       blink_mask = 8'h03;
          default: blink_mask = 8'($urandom);
        endcase
      end
      step();
    end

    eight_segment = DATE_WORD;
    blink_mask    = 8'h03;
    repeat (400) step();

    // Async reset in the middle of a lit dwell.
    while (t % 10 != 5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    @(posedge clk);
    #1;
    chk_idle("mid_rst_hold");
    eight_segment = TIME_WORD;
    blink_mask    = 8'h24;
    release_reset();
    repeat (240) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
